// File: rtl/mdl_dlcntr_pkg.sv
// Shared constants and slot decode for the bubble-data length counter.
// Slot indices follow the ROT20 frame used by the data-length evaluator.
package mdl_dl_pkg;

    localparam int DL_CNT_W       = 10;
    localparam int DL_BOOT_LEN    = 480;
    localparam int SLOT_CNT_FIRST = 0;
    localparam int SLOT_PG2B      = 7;
    localparam int SLOT_PG4B      = 8;
    localparam int SLOT_BOOT      = 9;
    localparam int SLOT_EVAL      = 10;

    typedef enum logic [1:0] {
        PH_NONE,
        PH_LOAD,
        PH_SHIFT,
        PH_HOLD
    } phase_t;

    // Lowest low bit wins; no low bit means a malformed frame, treated as hold.
    function automatic phase_t slot_phase(
        input logic [19:0] rot_n,
        input int          cnt_w
    );
        phase_t ph;
        ph = PH_NONE;
        for (int k = 19; k >= 0; k--) begin
            if (!rot_n[k]) begin
                if (k == SLOT_CNT_FIRST)
                    ph = PH_LOAD;
                else if (k < cnt_w)
                    ph = PH_SHIFT;
                else
                    ph = PH_HOLD;
            end
        end
        return ph;
    endfunction

endpackage

// File: rtl/mdl_dlcntr_if.sv
// Slot-strobe, request and result bundle of the data length counter.
interface mdl_dlcntr_if
    import mdl_dl_pkg::*;
#(
    parameter int CNT_W = DL_CNT_W
);
    logic             i_CLK2M_PCEN_n;
    logic [19:0]      i_ROT20_n;
    logic             i_INC;
    logic             i_DLCNTR_CLR;
    logic             o_DLCNTR_LSB;
    logic             o_DLCNTR_CFLAG;
    logic [CNT_W-1:0] o_DLCNTR_VAL;
    logic             o_INC_LOST;
    logic             o_WRAP;

    modport master (
        output i_CLK2M_PCEN_n, i_ROT20_n, i_INC, i_DLCNTR_CLR,
        input  o_DLCNTR_LSB, o_DLCNTR_CFLAG, o_DLCNTR_VAL,
        input  o_INC_LOST, o_WRAP
    );

    modport slave (
        input  i_CLK2M_PCEN_n, i_ROT20_n, i_INC, i_DLCNTR_CLR,
        output o_DLCNTR_LSB, o_DLCNTR_CFLAG, o_DLCNTR_VAL,
        output o_INC_LOST, o_WRAP
    );

endinterface

// File: rtl/mdl_dlcntr_serial_add.sv
// One-bit serial adder with its carry flop; ld injects the frame's carry-in
// combinationally so slot 0 sees the fresh increment.
module mdl_dlcntr_serial_add (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ld,
    input  logic ld_val,
    input  logic clr,
    input  logic a,
    output logic sum,
    output logic cout,
    output logic carry
);

    logic c_in;

    assign c_in = ld ? ld_val : carry;
    assign sum  = a ^ c_in;
    assign cout = a & c_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            carry <= 1'b0;
        else if (en)
            carry <= clr ? 1'b0 : cout;
    end

endmodule

// File: rtl/mdl_dlcntr.sv
// Serial data length counter: rotating count register, one bit per ROT20
// slot, with increment/clear request latches and lost/wrap flags.
module mdl_dlcntr
    import mdl_dl_pkg::*;
#(
    parameter int CNT_W = DL_CNT_W
) (
    input  logic        i_MCLK,
    input  logic        i_RST,
    mdl_dlcntr_if.slave bus
);

    logic [CNT_W-1:0] sr;
    logic             pending;
    logic             clr_pend;
    logic             lost_acc;
    logic             inc_lost;
    logic             wrap;

    phase_t ph;
    logic   en;
    logic   load;
    logic   step;
    logic   last;
    logic   clr_now;
    logic   lost_now;
    logic   sum;
    logic   cout;
    logic   carry;

    assign ph      = slot_phase(bus.i_ROT20_n, CNT_W);
    assign en      = ~bus.i_CLK2M_PCEN_n;
    assign load    = (ph == PH_LOAD);
    assign step    = en & ((ph == PH_LOAD) | (ph == PH_SHIFT));
    assign last    = ~bus.i_ROT20_n[CNT_W-1];
    assign clr_now = load & (clr_pend | bus.i_DLCNTR_CLR);

    // A request dropped by a clear is not reported as lost.
    assign lost_now = bus.i_INC & pending & ~(en & clr_now);

    mdl_dlcntr_serial_add u_add (
        .clk    (i_MCLK),
        .rst    (i_RST),
        .en     (step),
        .ld     (load),
        .ld_val (pending | bus.i_INC),
        .clr    (clr_now),
        .a      (sr[0]),
        .sum    (sum),
        .cout   (cout),
        .carry  (carry)
    );

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            sr       <= '0;
            pending  <= 1'b0;
            clr_pend <= 1'b0;
            lost_acc <= 1'b0;
            inc_lost <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            if (en & load) begin
                pending  <= 1'b0;
                clr_pend <= 1'b0;
            end else begin
                pending  <= pending | bus.i_INC;
                clr_pend <= clr_pend | bus.i_DLCNTR_CLR;
            end

            if (step)
                sr <= clr_now ? '0 : {sum, sr[CNT_W-1:1]};

            if (en & clr_now)
                wrap <= 1'b0;
            else if (step & last & cout)
                wrap <= 1'b1;

            // Losses seen between enables are folded into the next enable pulse.
            if (en) begin
                inc_lost <= lost_acc | lost_now;
                lost_acc <= 1'b0;
            end else begin
                lost_acc <= lost_acc | lost_now;
            end
        end
    end

    assign bus.o_DLCNTR_LSB   = sr[0];
    assign bus.o_DLCNTR_CFLAG = carry;
    assign bus.o_DLCNTR_VAL   = sr;
    assign bus.o_INC_LOST     = inc_lost;
    assign bus.o_WRAP         = wrap;

endmodule

// File: tb/tb_mdl_dlcntr.sv
// Directed bench for mdl_dlcntr: frame-level vector table plus hand-written
// sequences for carry ripple, wrap, clear and asynchronous reset.
module tb_mdl_dlcntr;

    localparam int CW = 10;

    logic clk;
    logic rst;

    mdl_dlcntr_if #(.CNT_W(CW)) bus ();

    mdl_dlcntr #(.CNT_W(CW)) dut (
        .i_MCLK (clk),
        .i_RST  (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst)
            assert ($countones(~bus.i_ROT20_n) <= 1)
                else $error("multiple ROT20 slots low");
    end

    typedef struct {
        bit inc0;
        int late;
        bit clr0;
        bit clr_late;
        bit stall;
        int exp_val;
        int exp_lost;
        bit exp_wrap;
    } vec_t;

    vec_t tbl [14];

    int total = 0;
    int bad   = 0;
    int cnt   = 0;

    logic [19:0] lsb_v;
    logic [19:0] cf_v;
    int          lost_n;
    int          f_val;
    logic        f_wrap;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(
        input bit inc0,
        input int late,
        input bit clr0,
        input bit clr_late,
        input bit stall
    );
        lost_n = 0;
        lsb_v  = '0;
        cf_v   = '0;
        for (int s = 0; s < 20; s++) begin
            if (stall) begin
                @(negedge clk);
                bus.i_ROT20_n      = ~(20'd1 << s);
                bus.i_CLK2M_PCEN_n = 1'b1;
                bus.i_INC          = 1'b0;
                bus.i_DLCNTR_CLR   = 1'b0;
            end
            @(negedge clk);
            bus.i_ROT20_n      = ~(20'd1 << s);
            bus.i_CLK2M_PCEN_n = 1'b0;
            bus.i_INC          = (s == 0 && inc0) ||
                                 (s == 12 && late >= 1) ||
                                 (s == 14 && late >= 2);
            bus.i_DLCNTR_CLR   = (s == 0 && clr0) || (s == 12 && clr_late);
            #1;
            lsb_v[s] = bus.o_DLCNTR_LSB;
            cf_v[s]  = bus.o_DLCNTR_CFLAG;
            if (bus.o_INC_LOST)
                lost_n++;
            if (s == 19) begin
                f_val  = int'(bus.o_DLCNTR_VAL);
                f_wrap = bus.o_WRAP;
            end
        end
    endtask

    // Carry into bit k when v is incremented: all lower bits of v are ones.
    function automatic logic [19:0] ripple(input int v);
        logic [19:0] r;
        r = '0;
        for (int k = 1; k < 20; k++)
            r[k] = ((v & ((1 << k) - 1)) == ((1 << k) - 1));
        return r;
    endfunction

    task automatic inc_to(input int target);
        while (cnt < target) begin
            run_frame(1, 0, 0, 0, 0);
            cnt++;
        end
    endtask

    initial begin
        tbl[0]  = '{0, 2, 0, 0, 0, 5, 1, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 6, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 6, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 7, 1, 0};
        tbl[4]  = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{0, 1, 0, 1, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 1, 1, 0, 0};
        tbl[9]  = '{1, 0, 0, 0, 1, 2, 0, 0};
        tbl[10] = '{0, 2, 0, 0, 1, 2, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 3, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 0, 3, 0, 0};
        tbl[13] = '{1, 0, 1, 0, 0, 0, 0, 0};

        bus.i_CLK2M_PCEN_n = 1'b1;
        bus.i_ROT20_n      = '1;
        bus.i_INC          = 1'b0;
        bus.i_DLCNTR_CLR   = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs",
              int'({bus.o_DLCNTR_LSB, bus.o_DLCNTR_CFLAG, bus.o_DLCNTR_VAL,
                    bus.o_INC_LOST, bus.o_WRAP}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int f = 0; f < 3; f++) begin
            run_frame(0, 0, 0, 0, 0);
            check("idle_lsb", int'(lsb_v), 0);
            check("idle_cflag", int'(cf_v), 0);
            check("idle_val", f_val, 0);
            check("idle_wrap", int'(f_wrap), 0);
        end

        for (int f = 1; f <= 5; f++) begin
            run_frame(1, 0, 0, 0, 0);
            check("inc_val", f_val, f);
        end
        run_frame(0, 0, 0, 0, 0);
        check("lsb_stream_5", int'(lsb_v[9:0]), 5);

        for (int i = 0; i < 14; i++) begin
            run_frame(tbl[i].inc0, tbl[i].late, tbl[i].clr0,
                      tbl[i].clr_late, tbl[i].stall);
            check($sformatf("vec%0d_val", i), f_val, tbl[i].exp_val);
            check($sformatf("vec%0d_lost", i), lost_n, tbl[i].exp_lost);
            check($sformatf("vec%0d_wrap", i), int'(f_wrap),
                  int'(tbl[i].exp_wrap));
        end

        cnt = 0;
        inc_to(127);
        run_frame(1, 0, 0, 0, 0);
        cnt++;
        check("pg2b_val", f_val, 128);
        check("pg2b_cflag", int'(cf_v[9:1]), int'(ripple(127) >> 1) & 9'h1ff);
        check("pg2b_slot7", int'(cf_v[7]), 1);

        inc_to(255);
        run_frame(1, 0, 0, 0, 0);
        cnt++;
        check("pg4b_val", f_val, 256);
        check("pg4b_cflag", int'(cf_v[9:1]), int'(ripple(255) >> 1) & 9'h1ff);
        check("pg4b_slot8", int'(cf_v[8]), 1);

        inc_to(479);
        check("boot_pre_val", f_val, 479);
        run_frame(0, 1, 0, 1, 0);
        check("boot_clr_hold", f_val, 479);
        run_frame(0, 0, 0, 0, 0);
        check("boot_clr_val", f_val, 0);
        check("boot_clr_lost", lost_n, 0);
        cnt = 0;

        inc_to(1023);
        check("max_val", f_val, 1023);
        run_frame(1, 0, 0, 0, 0);
        check("wrap_val", f_val, 0);
        check("wrap_set", int'(f_wrap), 1);
        run_frame(0, 0, 0, 1, 0);
        check("wrap_held", int'(f_wrap), 1);
        run_frame(0, 0, 0, 0, 0);
        check("wrap_cleared", int'(f_wrap), 0);
        check("wrap_clr_val", f_val, 0);

        for (int f = 0; f < 3; f++)
            run_frame(1, 0, 0, 0, 0);
        check("pre_rst_val", f_val, 3);
        for (int s = 0; s <= 4; s++) begin
            @(negedge clk);
            bus.i_ROT20_n      = ~(20'd1 << s);
            bus.i_CLK2M_PCEN_n = 1'b0;
            bus.i_INC          = (s == 2);
            bus.i_DLCNTR_CLR   = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_rst",
              int'({bus.o_DLCNTR_LSB, bus.o_DLCNTR_CFLAG, bus.o_DLCNTR_VAL,
                    bus.o_INC_LOST, bus.o_WRAP}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_frame(0, 0, 0, 0, 0);
        check("post_rst_val", f_val, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
